// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, complex sample type and bit-reverse helper
package fft_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] re;
        logic [DEFAULT_DATA_WIDTH-1:0] im;
    } cplx_t;

    // Reverses the low 'bits' bits of v; bits above are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < bits) begin
                r = (r << 1) | ((v >> b) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// rtl/fft_pingpong_bank.sv - two-bank sample store with full flags and fill/drain counters
module fft_pingpong_bank #(
    parameter int WIDTH = 128,
    parameter int N = 8,
    localparam int LOG2N = $clog2(N),
    localparam int JW = (LOG2N > 1) ? LOG2N - 1 : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [JW-1:0]    rd_cnt,
    input  logic [LOG2N-1:0] rd_addr_a,
    input  logic [LOG2N-1:0] rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
    localparam logic [JW-1:0]    RD_LAST = JW'(N / 2 - 1);

    logic [WIDTH-1:0] mem [2][N];
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_done;
    logic             rd_done;

    assign wr_ready = !full[wr_bank];
    assign rd_valid = full[rd_bank];
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_done  = wr_fire && (wr_cnt == WR_LAST);
    assign rd_done  = rd_fire && (rd_cnt == RD_LAST);

    // Fill and drain never address the same bank, so both flag updates apply.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
            if (wr_done) wr_bank <= !wr_bank;
            if (rd_fire) rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
            if (rd_done) rd_bank <= !rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_cnt] <= wr_data;
    end

    assign rd_data_a = mem[rd_bank][rd_addr_a];
    assign rd_data_b = mem[rd_bank][rd_addr_b];

endmodule

// File: rtl/fft_2_input_pairer.sv
// rtl/fft_2_input_pairer.sv - buffers natural-order frames and emits first-stage DIT butterfly pairs
module fft_2_input_pairer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = fft_pkg::DEFAULT_DATA_WIDTH,
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x1_r,
    output logic [DATA_WIDTH-1:0] x1_i,
    output logic [DATA_WIDTH-1:0] x2_r,
    output logic [DATA_WIDTH-1:0] x2_i,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int LOG2N = $clog2(N);
    localparam int JW    = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int W     = 2 * DATA_WIDTH;

    logic [JW-1:0]    j;
    logic [LOG2N-1:0] addr_lo;
    logic [LOG2N-1:0] addr_hi;
    logic [W-1:0]     d1;
    logic [W-1:0]     d2;

    // Pair j takes samples bitrev(j) and bitrev(j) + N/2 of the draining frame.
    always_comb begin
        addr_lo = LOG2N'(bitrev(32'(j), LOG2N - 1));
        addr_hi = addr_lo | LOG2N'(N / 2);
    end

    fft_pingpong_bank #(
        .WIDTH (W),
        .N     (N)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (in_valid),
        .wr_ready  (in_ready),
        .wr_data   ({in_r, in_i}),
        .rd_valid  (out_valid),
        .rd_ready  (out_ready),
        .rd_cnt    (j),
        .rd_addr_a (addr_lo),
        .rd_addr_b (addr_hi),
        .rd_data_a (d1),
        .rd_data_b (d2)
    );

    assign x1_r = out_valid ? d1[W-1:DATA_WIDTH] : '0;
    assign x1_i = out_valid ? d1[DATA_WIDTH-1:0] : '0;
    assign x2_r = out_valid ? d2[W-1:DATA_WIDTH] : '0;
    assign x2_i = out_valid ? d2[DATA_WIDTH-1:0] : '0;

    assign out_first = out_valid && (j == '0);
    assign out_last  = out_valid && (j == JW'(N / 2 - 1));

endmodule

// File: tb/tb_fft_2_input_pairer.sv
// tb/tb_fft_2_input_pairer.sv - directed and model-checked bench for fft_2_input_pairer
`timescale 1ns/1ps
module tb_fft_2_input_pairer;
    import fft_pkg::*;

    localparam int DW = 64;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, out_first, out_last;
    logic [DW-1:0] in_r, in_i, x1_r, x1_i, x2_r, x2_i;
    logic in_valid2, in_ready2, out_valid2, out_ready2, out_first2, out_last2;
    logic [DW-1:0] in_r2, in_i2, x1_r2, x1_i2, x2_r2, x2_i2;

    always #5 clk = ~clk;

    fft_2_input_pairer #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
        .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i),
        .out_first(out_first), .out_last(out_last)
    );

    fft_2_input_pairer #(.DATA_WIDTH(DW), .N(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_r(in_r2), .in_i(in_i2), .out_valid(out_valid2), .out_ready(out_ready2),
        .x1_r(x1_r2), .x1_i(x1_i2), .x2_r(x2_r2), .x2_i(x2_i2),
        .out_first(out_first2), .out_last(out_last2)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          e_irdy;
        logic          e_ovld;
        logic [DW-1:0] e_x1;
        logic [DW-1:0] e_x2;
        logic          e_first;
        logic          e_last;
    } vec_t;

    typedef struct {
        cplx_t a;
        cplx_t b;
        logic  first;
        logic  last;
    } pair_t;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t  tbl[13];
    cplx_t part_q[$];
    pair_t exp_q[$];
    int    frames_full = 0;
    int    br_tbl[4] = '{0, 2, 1, 3};
    int    sent;
    int    cyc;
    logic  acc;
    logic  iv_r;
    logic  or_r;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic cplx_t mk(input logic [DW-1:0] r, input logic [DW-1:0] i);
        cplx_t c;
        c.re = r;
        c.im = i;
        return c;
    endfunction

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(4))
            0: return 64'h8000_0000_0000_0000;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return '1;
            3: return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One cycle: drive at negedge, check outputs against the frame-level model, then advance it.
    task automatic step(input logic iv, input cplx_t s, input logic ordy, output logic accepted);
        logic  xfer;
        pair_t p;
        @(negedge clk);
        in_valid  = iv;
        in_r      = s.re;
        in_i      = s.im;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, frames_full < 2);
        chk("out_valid", out_valid, frames_full > 0);
        if (exp_q.size() > 0) begin
            chk("x1_r", x1_r, exp_q[0].a.re);
            chk("x1_i", x1_i, exp_q[0].a.im);
            chk("x2_r", x2_r, exp_q[0].b.re);
            chk("x2_i", x2_i, exp_q[0].b.im);
            chk("out_first", out_first, exp_q[0].first);
            chk("out_last", out_last, exp_q[0].last);
        end else begin
            chk("x1_r_idle", x1_r, 0);
            chk("x2_r_idle", x2_r, 0);
            chk("first_idle", out_first, 0);
            chk("last_idle", out_last, 0);
        end
        accepted = iv && (frames_full < 2);
        xfer     = ordy && (exp_q.size() > 0);
        if (xfer) begin
            p = exp_q.pop_front();
            if (p.last) frames_full--;
        end
        if (accepted) begin
            part_q.push_back(s);
            if (part_q.size() == N) begin
                for (int jj = 0; jj < N / 2; jj++) begin
                    p.a     = part_q[br_tbl[jj]];
                    p.b     = part_q[br_tbl[jj] + N / 2];
                    p.first = (jj == 0);
                    p.last  = (jj == N / 2 - 1);
                    exp_q.push_back(p);
                end
                part_q.delete();
                frames_full++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_r = 0; in_i = 0; out_ready = 0;
        in_valid2 = 0; in_r2 = 0; in_i2 = 0; out_ready2 = 0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x1_r", x1_r, 0);
        chk("rst_x2_i", x2_i, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame 0..7, hand-computed pairs (0,4) (2,6) (1,5) (3,7).
        for (int k = 0; k < 8; k++) tbl[k] = '{1'b1, 64'(k), 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd0, 64'd4, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd2, 64'd6, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd1, 64'd5, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd3, 64'd7, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            in_r      = tbl[i].din;
            in_i      = tbl[i].din + 100;
            out_ready = tbl[i].ordy;
            #1;
            chk("tbl_in_ready", in_ready, tbl[i].e_irdy);
            chk("tbl_out_valid", out_valid, tbl[i].e_ovld);
            chk("tbl_x1_r", x1_r, tbl[i].e_x1);
            chk("tbl_x2_r", x2_r, tbl[i].e_x2);
            chk("tbl_x1_i", x1_i, tbl[i].e_ovld ? tbl[i].e_x1 + 100 : 64'd0);
            chk("tbl_x2_i", x2_i, tbl[i].e_ovld ? tbl[i].e_x2 + 100 : 64'd0);
            chk("tbl_first", out_first, tbl[i].e_first);
            chk("tbl_last", out_last, tbl[i].e_last);
        end

        // Three back-to-back frames at full rate.
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++) step(1'b1, mk(64'(f * 16 + k), 64'(f * 16 + k + 1000)), 1'b1, acc);
        for (int k = 0; k < 5; k++) step(1'b0, mk(0, 0), 1'b1, acc);
        chk("b2b_drained", 64'(exp_q.size()), 0);

        // Output stalled while two frames fill, then a 4-cycle drain frees a bank.
        for (int k = 0; k < 2 * N; k++) step(1'b1, mk(64'(200 + k), 64'(300 + k)), 1'b0, acc);
        for (int k = 0; k < 3; k++) step(1'b1, mk(64'd999, 64'd999), 1'b0, acc);
        for (int k = 0; k < 4; k++) step(1'b0, mk(0, 0), 1'b1, acc);
        step(1'b0, mk(0, 0), 1'b0, acc);
        for (int k = 0; k < 5; k++) step(1'b0, mk(0, 0), 1'b1, acc);
        chk("stall_drained", 64'(exp_q.size()), 0);

        // Random gaps over 20 frames with signed extremes.
        sent = 0;
        cyc  = 0;
        while ((sent < 20 * N || exp_q.size() > 0) && cyc < 4000) begin
            iv_r = (sent < 20 * N) && ($urandom_range(3) != 0);
            or_r = ($urandom_range(2) != 0);
            step(iv_r, mk(pick(), pick()), or_r, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("random_complete", 64'((sent == 20 * N) && (exp_q.size() == 0)), 1);

        // Reset with frame 0 mid-drain at j = 2 and 5 samples of frame 1 written.
        for (int k = 0; k < N; k++) step(1'b1, mk(64'(k), 64'(100 + k)), 1'b0, acc);
        for (int k = 0; k < 5; k++) step(1'b1, mk(64'(50 + k), 64'(150 + k)), k < 2, acc);
        @(negedge clk);
        in_valid = 0;
        out_ready = 0;
        #1;
        chk("pre_reset_x1_r", x1_r, 1);
        chk("pre_reset_x2_r", x2_r, 5);
        rst = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_x1_r", x1_r, 0);
        chk("reset_first", out_first, 0);
        part_q.delete();
        exp_q.delete();
        frames_full = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) step(1'b1, mk(64'(k), 64'(100 + k)), 1'b1, acc);
        for (int k = 0; k < 5; k++) step(1'b0, mk(0, 0), 1'b1, acc);
        chk("post_reset_drained", 64'(exp_q.size()), 0);

        // N = 2 instance: samples 3 and 9 form one pair.
        @(negedge clk);
        chk("n2_in_ready", in_ready2, 1);
        in_valid2 = 1; in_r2 = 3; in_i2 = 103;
        @(negedge clk);
        in_r2 = 9; in_i2 = 109;
        @(negedge clk);
        in_valid2 = 0;
        #1;
        chk("n2_out_valid", out_valid2, 1);
        chk("n2_x1_r", x1_r2, 3);
        chk("n2_x2_r", x2_r2, 9);
        chk("n2_x1_i", x1_i2, 103);
        chk("n2_x2_i", x2_i2, 109);
        chk("n2_first", out_first2, 1);
        chk("n2_last", out_last2, 1);
        out_ready2 = 1;
        @(negedge clk);
        #1;
        chk("n2_drained", out_valid2, 0);
        chk("n2_first_idle", out_first2, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
